vec_mul_ctrl: RTL and testbench
===============================

Name: vec_mul_ctrl

Overview:
- Job sequencer and stream wrapper around the pipelined signed dot-product unit `vec_mul`. That unit multiplies C k/x lanes, reduces them through a registered adder tree, and has a single global enable.
- Accepts a job of N rows over a valid/ready input stream, drives the unit's enable as a pipeline-wide stall, and tracks in-flight rows with a valid shift register.
- Emits one W_Y-bit result per row on a valid/ready output stream, with a last flag and a done pulse.
- Sits between the PE's operand fetch and the result writeback.

Parameters:
- C, 8, lanes per row (passed to vec_mul)
- W_X, 8, x lane width (signed)
- W_K, 8, k lane width (signed)
- W_N, 16, row-count width
- derived, not overridable: DEPTH=$clog2(C); W_Y=W_X+W_K+DEPTH; L=DEPTH+1 (pipeline latency)

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  one-cycle job start; sampled only in IDLE
- n_rows  in  W_N  rows in job, sampled with start
- busy  out  1  high in RUN/DRAIN/DONE
- done  out  1  one-cycle pulse at job end
- s_valid  in  1  input row valid
- s_ready  out  1  input row accepted when s_valid&&s_ready
- s_k  in  C*W_K  packed signed k lanes, lane 0 at LSBs
- s_x  in  C*W_X  packed signed x lanes
- m_valid  out  1  result valid
- m_ready  in  1  result consumed when m_valid&&m_ready
- m_data  out  W_Y  signed dot product
- m_last  out  1  high with final row's result

Behaviour:
- Reset, synchronous on rstn=0 at the clock edge, including mid-job:
  - FSM to IDLE; valid shift register, in-count and out-count cleared.
  - busy=0, done=0, s_ready=0, m_valid=0, m_last=0.
  - Datapath registers have no reset. Stale contents are never emitted, because valid bits gate all output.
- Stall: stall = m_valid && !m_ready. vec_mul enable = !stall.
  - The whole pipeline and the valid shift register freeze together, so m_data/m_valid/m_last stay stable until accepted.
- Valid shift register, vsr[L-1:0]: advances when enable=1.
  - vsr[0] <= input handshake this cycle.
  - m_valid = vsr[L-1]; m_data = vec_mul y.
  - Bubbles advance with enable=1 and carry 0. Latency is exactly L cycles from accept to m_valid when unstalled.
- Tail tag: a parallel L-bit last-tag shift register, advancing with vsr, carries "final row of job". m_last = tag[L-1] && m_valid.
- s_ready = (state==RUN) && !stall && (in_cnt < n_rows_q).
- FSM states and transitions:
  - IDLE: start=1 and n_rows≠0 → RUN, latching n_rows_q and clearing counters. start=1 and n_rows=0 → DONE, with no data.
  - RUN: count accepted rows in in_cnt. The final input handshake sets the tail tag → DRAIN.
  - DRAIN: count output handshakes in out_cnt. The handshake with m_last → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- start outside IDLE is ignored.
- s_valid with s_ready=0 is ignored; no implicit capture.
- Simultaneous events:
  - Input and output handshake in the same cycle are both legal; throughput is 1 row/cycle.
  - Output handshake and pipeline shift occur in the same edge.
- Arithmetic: full-precision signed, no saturation. The result range is always representable in W_Y.
- Counters are W_N wide. n_rows_q ≤ 2^W_N−1, so there is no wrap.

Decomposition:
- Package vec_mul_pkg holds:
  - defaults C/W_X/W_K/W_N, with localparams DEPTH, W_Y and L;
  - enum ctrl_state_e {IDLE,RUN,DRAIN,DONE}.
- One sub-module: the existing vec_mul instance u_dp. The controller contains only FSM, counters and shift registers.

Test Plan (C=8, W=8, L=4, W_Y=19):
1. rstn=0 for 2 cycles → busy=0, done=0, s_ready=0, m_valid=0, m_last=0. Datapath X never reaches m_valid.
2. start, n_rows=1, k all 1, x=1..8, m_ready=1 → m_valid with m_data=36 and m_last=1 exactly 4 cycles after accept. done pulses 1 cycle after the output handshake. busy=0 the cycle after done.
3. Signed extremes, n_rows=2:
   - k=−128 ×8, x=−128 ×8 → 131072;
   - k=−128, x=127 → −130048; m_last only on the second.
4. n_rows=5 back-to-back, m_ready=0 for 3 cycles while results are pending → s_ready=0 during the stall, m_data held stable. 5 results in order, none lost or duplicated; m_last on the 5th.
5. start with n_rows=0 → done pulse the cycle after DONE entry, no m_valid. A start pulse during RUN → ignored, count unchanged.
6. n_rows=4, rstn=0 after 2 rows accepted → next cycle m_valid=0 and busy=0. New start with n_rows=1 → exactly one correct result, no stale output.

Source files
------------

// File: rtl/vec_mul_pkg.sv
// Shared defaults and controller state encoding for the vec_mul job sequencer.
// Derived sizes are recomputed locally by each module from its own parameters.
package vec_mul_pkg;

    localparam int C_DEF     = 8;
    localparam int W_X_DEF   = 8;
    localparam int W_K_DEF   = 8;
    localparam int W_N_DEF   = 16;
    localparam int DEPTH_DEF = $clog2(C_DEF);
    localparam int W_Y_DEF   = W_X_DEF + W_K_DEF + DEPTH_DEF;
    localparam int L_DEF     = DEPTH_DEF + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/vec_mul.sv
// Pipelined signed dot product: registered lane products, then a registered
// binary adder tree. Latency is $clog2(C)+1 cycles; i_en freezes every stage.
module vec_mul
    import vec_mul_pkg::*;
#(
    parameter  int C     = C_DEF,
    parameter  int W_X   = W_X_DEF,
    parameter  int W_K   = W_K_DEF,
    localparam int DEPTH = $clog2(C),
    localparam int W_Y   = W_X + W_K + DEPTH
) (
    input  logic                   clk,
    input  logic                   i_en,
    input  logic [C*W_K-1:0]       i_k,
    input  logic [C*W_X-1:0]       i_x,
    output logic signed [W_Y-1:0]  o_y
);

    localparam int W_P = W_X + W_K;

    // Heap-ordered tree: leaves at [C..2C-1], node n sums nodes 2n and 2n+1.
    logic signed [W_Y-1:0] r_node [1:2*C-1];
    logic signed [W_Y-1:0] w_prod [C];

    for (genvar i = 0; i < C; i++) begin : g_lane
        logic signed [W_K-1:0] w_k;
        logic signed [W_X-1:0] w_x;
        logic signed [W_P-1:0] w_p;
        assign w_k       = i_k[i*W_K +: W_K];
        assign w_x       = i_x[i*W_X +: W_X];
        assign w_p       = w_k * w_x;
        assign w_prod[i] = {{DEPTH{w_p[W_P-1]}}, w_p};
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < C; i++) begin
                r_node[C+i] <= w_prod[i];
            end
            for (int n = 1; n < C; n++) begin
                r_node[n] <= r_node[2*n] + r_node[2*n+1];
            end
        end
    end

    assign o_y = r_node[1];

endmodule

// File: rtl/vec_mul_ctrl.sv
// Job sequencer and valid/ready wrapper around vec_mul: a stall freezes the
// datapath and the valid/last shift registers together so outputs hold.
module vec_mul_ctrl
    import vec_mul_pkg::*;
#(
    parameter  int C     = C_DEF,
    parameter  int W_X   = W_X_DEF,
    parameter  int W_K   = W_K_DEF,
    parameter  int W_N   = W_N_DEF,
    localparam int DEPTH = $clog2(C),
    localparam int W_Y   = W_X + W_K + DEPTH,
    localparam int L     = DEPTH + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [W_N-1:0]        n_rows,
    output logic                  busy,
    output logic                  done,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [C*W_K-1:0]      s_k,
    input  logic [C*W_X-1:0]      s_x,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [W_Y-1:0] m_data,
    output logic                  m_last,
    output ctrl_state_e           o_state,
    output logic [W_N-1:0]        o_rows_out
);

    ctrl_state_e    r_state;
    logic [L-1:0]   r_vsr;
    logic [L-1:0]   r_tag;
    logic [W_N-1:0] r_in_cnt;
    logic [W_N-1:0] r_out_cnt;
    logic [W_N-1:0] r_n_rows_q;

    logic w_stall;
    logic w_en;
    logic w_s_hs;
    logic w_m_hs;
    logic w_last_in;

    // Handshake rule for both streams: a beat transfers on the rising edge where
    // valid && ready; valid from the result side never drops before transfer.
    assign w_stall   = m_valid && !m_ready;
    assign w_en      = !w_stall;
    assign s_ready   = (r_state == RUN) && !w_stall && (r_in_cnt < r_n_rows_q);
    assign w_s_hs    = s_valid && s_ready;
    assign w_m_hs    = m_valid && m_ready;
    assign w_last_in = w_s_hs && (r_in_cnt == r_n_rows_q - W_N'(1));

    assign m_valid    = r_vsr[L-1];
    assign m_last     = r_tag[L-1] && m_valid;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign o_state    = r_state;
    assign o_rows_out = r_out_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_vsr      <= '0;
            r_tag      <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_n_rows_q <= '0;
        end else begin
            if (w_en) begin
                r_vsr <= {r_vsr[L-2:0], w_s_hs};
                r_tag <= {r_tag[L-2:0], w_last_in};
            end
            if (w_s_hs) r_in_cnt <= r_in_cnt + W_N'(1);
            if (w_m_hs) r_out_cnt <= r_out_cnt + W_N'(1);

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n_rows_q <= n_rows;
                        r_in_cnt   <= '0;
                        r_out_cnt  <= '0;
                        r_state    <= (n_rows == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_last_in) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_m_hs && m_last) r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    vec_mul #(
        .C   (C),
        .W_X (W_X),
        .W_K (W_K)
    ) u_dp (
        .clk  (clk),
        .i_en (w_en),
        .i_k  (s_k),
        .i_x  (s_x),
        .o_y  (m_data)
    );

endmodule

// File: tb/tb_vec_mul_ctrl.sv
// Directed bench for vec_mul_ctrl with hand-computed dot products (C=8, 8-bit lanes).
module tb_vec_mul_ctrl;
  import vec_mul_pkg::*;

  localparam int NV = 7;

  logic               clk;
  logic               rstn;
  logic               start;
  logic [15:0]        n_rows;
  logic               busy;
  logic               done;
  logic               s_valid;
  logic               s_ready;
  logic [63:0]        s_k;
  logic [63:0]        s_x;
  logic               m_valid;
  logic               m_ready;
  logic signed [18:0] m_data;
  logic               m_last;
  ctrl_state_e        st;
  logic [15:0]        rows_out;

  typedef struct {
    logic [63:0] k;
    logic [63:0] x;
    int          y;
  } vec_t;

  vec_t vec [NV];
  int   exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   got_n;

  vec_mul_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .n_rows     (n_rows),
    .busy       (busy),
    .done       (done),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_k        (s_k),
    .s_x        (s_x),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .o_state    (st),
    .o_rows_out (rows_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // driver + scoreboard for one job; stall_n cycles of m_ready=0 on first result
  task automatic run_job(input int n, input int first, input int stall_n,
                         input bit poke, output int n_out);
    int sent = 0;
    int got = 0;
    int stalled = 0;
    int cyc = 0;
    bit seen_done = 0;
    bit holding = 0;
    logic signed [18:0] held = '0;
    int e;
    start = 1'b1;
    n_rows = 16'(n);
    step();
    start = 1'b0;
    while (!seen_done && cyc < 200) begin
      start = poke && (cyc == 1);
      n_rows = poke ? 16'd7 : 16'(n);
      if (sent < n) begin
        s_valid = 1'b1;
        s_k = vec[(first + sent) % NV].k;
        s_x = vec[(first + sent) % NV].x;
      end else begin
        s_valid = 1'b0;
      end
      m_ready = !(m_valid && stalled < stall_n);
      #1;
      if (!m_ready) begin
        chk("s_ready_in_stall", s_ready, 0);
        if (holding) chk("m_data_held", m_data, held);
        held = m_data;
        holding = 1;
        stalled++;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(vec[(first + sent) % NV].y);
        sent++;
      end
      if (m_valid && m_ready) begin
        got++;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", m_data, 0);
          n_errors += (m_data == 0) ? 1 : 0;
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e);
        end
        chk("m_last", m_last, (got == n) ? 1 : 0);
      end
      if (done) seen_done = 1;
      step();
      cyc++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("job_done_seen", seen_done, 1);
    chk("job_result_count", got, n);
    chk("rows_out", rows_out, n);
    chk("busy_after_done", busy, 0);
    chk("exp_q_empty", exp_q.size(), 0);
    exp_q.delete();
    n_out = got;
  endtask

  initial begin
    vec[0] = '{64'h0101010101010101, 64'h0807060504030201, 36};
    vec[1] = '{64'h8080808080808080, 64'h8080808080808080, 131072};
    vec[2] = '{64'h8080808080808080, 64'h7F7F7F7F7F7F7F7F, -130048};
    vec[3] = '{64'hFF01FF01FF01FF01, 64'h0807060504030201, -4};
    vec[4] = '{64'h0303030303030303, 64'hFFFFFFFFFFFFFFFF, -24};
    vec[5] = '{64'h0706050403020100, 64'h0202020202020202, 56};
    vec[6] = '{64'h7F7F7F7F7F7F7F7F, 64'h7F7F7F7F7F7F7F7F, 129032};

    rstn = 1'b0; start = 1'b0; n_rows = '0;
    s_valid = 1'b0; s_k = '0; s_x = '0; m_ready = 1'b0;

    // 1: reset state
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    rstn = 1'b1;
    step();
    step();
    chk("idle_m_valid", m_valid, 0);
    chk("idle_busy", busy, 0);

    // 2: single row, exact latency and done timing
    m_ready = 1'b1;
    start = 1'b1; n_rows = 16'd1;
    step();
    start = 1'b0;
    chk("t2_busy", busy, 1);
    s_valid = 1'b1; s_k = vec[0].k; s_x = vec[0].x;
    #1;
    chk("t2_s_ready", s_ready, 1);
    step();
    s_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("t2_m_valid_early", m_valid, 0);
      step();
    end
    chk("t2_m_valid", m_valid, 1);
    chk("t2_m_data", m_data, 36);
    chk("t2_m_last", m_last, 1);
    chk("t2_done_early", done, 0);
    step();
    chk("t2_done", done, 1);
    chk("t2_m_valid_after", m_valid, 0);
    step();
    chk("t2_done_pulse", done, 0);
    chk("t2_busy_after", busy, 0);

    // 3: signed extremes, m_last only on second
    run_job(2, 1, 0, 0, got_n);

    // 4: five rows back to back with a 3-cycle output stall
    run_job(5, 3, 3, 0, got_n);

    // 5: empty job, then a start pulse during RUN
    start = 1'b1; n_rows = 16'd0;
    step();
    start = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_m_valid", m_valid, 0);
    step();
    chk("t5_done_pulse", done, 0);
    chk("t5_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_m_valid", m_valid, 0);
      step();
    end
    run_job(3, 4, 0, 1, got_n);

    // 6: reset mid-job, then a clean single-row job
    start = 1'b1; n_rows = 16'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_k = vec[i].k; s_x = vec[i].x;
      #1;
      chk("t6_s_ready", s_ready, 1);
      step();
    end
    s_valid = 1'b0;
    rstn = 1'b0;
    step();
    chk("t6_rst_m_valid", m_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_s_ready", s_ready, 0);
    rstn = 1'b1;
    step();
    run_job(1, 5, 0, 0, got_n);
    for (int i = 0; i < 6; i++) begin
      chk("t6_no_stale", m_valid, 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
